// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and frame constants for the instruction-memory
//               loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
    localparam int         BYTE_W         = 8;
    localparam int         WORD_W         = 32;
    localparam int         CNT_W          = 16;
    localparam int         BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    // True while a frame is being received (timeout counter armed).
    function automatic logic in_frame(input state_t s);
        return (s == CNT_HI) || (s == CNT_LO) || (s == DATA) || (s == CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a framed program image as a byte stream, writes it
//               word by word into instruction memory and holds the CPU in
//               reset until a checksum-verified load completes.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W      = 12,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                c_to_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYC - 1);
    localparam logic [31:0]       c_depth   = 32'd1 << ADDR_W;

    state_t              r_state;
    logic                r_rx_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [WORD_W-1:0]   r_imem_wdata;
    logic                r_cpu_rst;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W:0]     r_idx;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;
    logic [BYTE_W-1:0]   r_csum;
    logic [c_to_w-1:0]   r_idle;

    logic                w_accept;
    logic [CNT_W-1:0]    w_n;
    logic                w_n_bad;
    logic [ADDR_W:0]     w_idx_next;
    logic                w_last_word;
    logic                w_timeout;

    assign w_accept    = rx_valid & r_rx_ready;
    assign w_n         = {r_cnt[15:8], rx_data};
    assign w_n_bad     = (w_n == '0) || (32'(w_n) > c_depth);
    assign w_idx_next  = r_idx + 1'b1;
    assign w_last_word = (32'(w_idx_next) == 32'(r_cnt));
    assign w_timeout   = (r_idle == c_to_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rx_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_csum       <= '0;
            r_idle       <= '0;
        end else begin
            r_rx_ready <= 1'b1;
            r_imem_we  <= 1'b0;

            // An accepted byte always beats a same-cycle terminal count.
            if (in_frame(r_state)) begin
                if (w_accept) begin
                    r_idle <= '0;
                end else if (w_timeout) begin
                    r_idle    <= '0;
                    r_state   <= ERR;
                    r_err     <= 1'b1;
                    r_busy    <= 1'b0;
                    r_cpu_rst <= 1'b1;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end else begin
                r_idle <= '0;
            end

            case (r_state)
                IDLE, DONE, ERR: begin
                    if (w_accept && (rx_data == MAGIC)) begin
                        r_state   <= CNT_HI;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                        r_csum    <= '0;
                    end
                end
                CNT_HI: begin
                    if (w_accept) begin
                        r_cnt   <= {rx_data, r_cnt[7:0]};
                        r_state <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (w_accept) begin
                        r_cnt <= w_n;
                        if (w_n_bad) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= DATA;
                            r_idx      <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_shift    <= {r_shift[15:0], rx_data};
                        r_csum     <= r_csum ^ rx_data;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_idx[ADDR_W-1:0];
                            r_imem_wdata <= {r_shift, rx_data};
                            r_idx        <= w_idx_next;
                            if (w_last_word) begin
                                r_state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (w_accept) begin
                        r_busy <= 1'b0;
                        if (rx_data == r_csum) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire
